// File: rtl/mem_pkg.sv
// Shared types and constants for the dual-channel memory responder.
package mem_pkg;

   localparam int MEM_WORDS_DEFAULT = 4096;
   localparam int WORD_SHIFT        = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic [63:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } req_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } resp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; last_grant advances only on an accepted grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_grant_q;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst)
         last_grant_q <= 1'b0;
      else if (accept)
         last_grant_q <= grant[1];
   end

endmodule

// File: rtl/mem_responder.sv
// Arbitrates two request channels onto one synchronous RAM, one transaction in flight.
module mem_responder
   import mem_pkg::*;
#(
   parameter int RAM_LATENCY = 1,
   parameter int MEM_WORDS   = MEM_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req_valid,
   output logic        p0_req_ready,
   input  logic [63:0] p0_addr,
   input  logic        p0_we,
   input  logic [63:0] p0_wdata,
   input  logic [7:0]  p0_wmask,
   output logic        p0_resp_valid,
   output logic [63:0] p0_resp_rdata,
   output logic        p0_resp_err,
   input  logic        p1_req_valid,
   output logic        p1_req_ready,
   input  logic [63:0] p1_addr,
   input  logic        p1_we,
   input  logic [63:0] p1_wdata,
   input  logic [7:0]  p1_wmask,
   output logic        p1_resp_valid,
   output logic [63:0] p1_resp_rdata,
   output logic        p1_resp_err,
   output logic        ram_en,
   output logic        ram_we,
   output logic [60:0] ram_addr,
   output logic [63:0] ram_wdata,
   output logic [7:0]  ram_wmask,
   input  logic [63:0] ram_rdata
);

   localparam int CW = $clog2(RAM_LATENCY + 1);

   state_e        state_q, state_d;
   req_t          req_q, sel_req;
   resp_t         resp_q;
   logic          owner_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    grant;
   logic          accept;
   logic          in_range;
   logic          unused_addr_bits;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({p1_req_valid, p0_req_valid}),
      .accept (accept),
      .grant  (grant)
   );

   // Outputs are forced low while rst is high, even before the state register clears.
   assign p0_req_ready = !rst && (state_q == IDLE) && grant[0];
   assign p1_req_ready = !rst && (state_q == IDLE) && grant[1];
   assign accept       = p0_req_ready || p1_req_ready;

   always_comb begin
      sel_req = grant[1] ? '{p1_addr, p1_we, p1_wdata, p1_wmask}
                         : '{p0_addr, p0_we, p0_wdata, p0_wmask};
   end

   assign in_range         = sel_req.addr[63:WORD_SHIFT] < 61'(MEM_WORDS);
   assign unused_addr_bits = ^req_q.addr[WORD_SHIFT-1:0];

   always_comb begin
      state_d   = state_q;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wmask = '0;
      case (state_q)
         IDLE:  if (accept) state_d = in_range ? ISSUE : RESP;
         ISSUE: begin
            state_d   = WAIT;
            ram_en    = !rst;
            ram_we    = !rst && req_q.we;
            ram_addr  = rst ? '0 : req_q.addr[63:WORD_SHIFT];
            ram_wdata = rst ? '0 : req_q.wdata;
            ram_wmask = rst ? '0 : req_q.wmask;
         end
         WAIT:  if (cnt_q == CW'(1)) state_d = RESP;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         resp_q  <= '0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_q        <= sel_req;
            owner_q      <= grant[1];
            resp_q.rdata <= '0;
            resp_q.err   <= !in_range;
         end
         if (state_q == ISSUE)
            cnt_q <= CW'(RAM_LATENCY);
         else if (state_q == WAIT) begin
            cnt_q <= cnt_q - CW'(1);
            // Read data lines up with the last WAIT cycle; writes keep rdata at 0.
            if (cnt_q == CW'(1) && !req_q.we)
               resp_q.rdata <= ram_rdata;
         end
      end
   end

   assign p0_resp_valid = !rst && (state_q == RESP) && !owner_q;
   assign p1_resp_valid = !rst && (state_q == RESP) &&  owner_q;
   assign p0_resp_rdata = p0_resp_valid ? resp_q.rdata : '0;
   assign p1_resp_rdata = p1_resp_valid ? resp_q.rdata : '0;
   assign p0_resp_err   = p0_resp_valid && resp_q.err;
   assign p1_resp_err   = p1_resp_valid && resp_q.err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default-latency instance plus a RAM_LATENCY=3 instance.
module tb_mem_responder;

   logic clk = 1'b0;
   logic rst;

   logic        p0_req_valid, p0_req_ready, p0_we, p0_resp_valid, p0_resp_err;
   logic [63:0] p0_addr, p0_wdata, p0_resp_rdata;
   logic [7:0]  p0_wmask;
   logic        p1_req_valid, p1_req_ready, p1_we, p1_resp_valid, p1_resp_err;
   logic [63:0] p1_addr, p1_wdata, p1_resp_rdata;
   logic [7:0]  p1_wmask;
   logic        ram_en, ram_we;
   logic [60:0] ram_addr;
   logic [63:0] ram_wdata, ram_rdata;
   logic [7:0]  ram_wmask;

   logic        b_p0_req_valid, b_p0_req_ready, b_p0_we, b_p0_resp_valid, b_p0_resp_err;
   logic [63:0] b_p0_addr, b_p0_wdata, b_p0_resp_rdata;
   logic [7:0]  b_p0_wmask;
   logic        b_p1_req_valid, b_p1_req_ready, b_p1_we, b_p1_resp_valid, b_p1_resp_err;
   logic [63:0] b_p1_addr, b_p1_wdata, b_p1_resp_rdata;
   logic [7:0]  b_p1_wmask;
   logic        b_ram_en, b_ram_we;
   logic [60:0] b_ram_addr;
   logic [63:0] b_ram_wdata, b_ram_rdata;
   logic [7:0]  b_ram_wmask;

   logic [63:0] mem [0:4095];
   logic [63:0] rd0, b_rd0, b_rd1, b_rd2;
   int compared = 0, mismatched = 0;
   int en_cnt = 0, p0_resp_cnt = 0;
   int en_before, resp_before;

   mem_responder dut (
      .clk(clk), .rst(rst),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
      .p0_we(p0_we), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
      .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
      .p1_we(p1_we), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
      .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
   );

   mem_responder #(.RAM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .p0_req_valid(b_p0_req_valid), .p0_req_ready(b_p0_req_ready), .p0_addr(b_p0_addr),
      .p0_we(b_p0_we), .p0_wdata(b_p0_wdata), .p0_wmask(b_p0_wmask),
      .p0_resp_valid(b_p0_resp_valid), .p0_resp_rdata(b_p0_resp_rdata), .p0_resp_err(b_p0_resp_err),
      .p1_req_valid(b_p1_req_valid), .p1_req_ready(b_p1_req_ready), .p1_addr(b_p1_addr),
      .p1_we(b_p1_we), .p1_wdata(b_p1_wdata), .p1_wmask(b_p1_wmask),
      .p1_resp_valid(b_p1_resp_valid), .p1_resp_rdata(b_p1_resp_rdata), .p1_resp_err(b_p1_resp_err),
      .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
      .ram_wmask(b_ram_wmask), .ram_rdata(b_ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM models: one-cycle read for dut, three-stage read pipeline for dut3 (read-only).
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we)
            for (int b = 0; b < 8; b++)
               if (ram_wmask[b]) mem[ram_addr[11:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
         rd0 <= mem[ram_addr[11:0]];
      end
      b_rd0 <= b_ram_en ? mem[b_ram_addr[11:0]] : 64'hX;
      b_rd1 <= b_rd0;
      b_rd2 <= b_rd1;
      if (ram_en)        en_cnt      <= en_cnt + 1;
      if (p0_resp_valid) p0_resp_cnt <= p0_resp_cnt + 1;
   end
   assign ram_rdata   = rd0;
   assign b_ram_rdata = b_rd2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 64'(i) * 64'h0101;
      mem[0] = 64'h0000_0000_CAFE_F00D;
      mem[1] = 64'h0123_4567_89AB_CDEF;
      mem[2] = 64'hAAAA_BBBB_CCCC_DDDD;
      mem[8] = 64'hDEAD_BEEF_0000_0001;
      rst = 1'b1;
      {p0_req_valid, p0_we, p0_addr, p0_wdata, p0_wmask} = '0;
      {p1_req_valid, p1_we, p1_addr, p1_wdata, p1_wmask} = '0;
      {b_p0_req_valid, b_p0_we, b_p0_addr, b_p0_wdata, b_p0_wmask} = '0;
      {b_p1_req_valid, b_p1_we, b_p1_addr, b_p1_wdata, b_p1_wmask} = '0;

      // Reset state, with a request pending to show ready is held low.
      tick(); p0_req_valid = 1'b1; #1;
      chk("rst_p0_ready", p0_req_ready, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_p0_resp_valid", p0_resp_valid, 0);
      chk("rst_p1_resp_valid", p1_resp_valid, 0);
      tick(); p0_req_valid = 1'b0; rst = 1'b0;

      // 1: p0 read of 0x40.
      tick(); p0_req_valid = 1'b1; p0_addr = 64'h40; #1;
      chk("t1_p0_ready", p0_req_ready, 1);
      chk("t1_p1_ready", p1_req_ready, 0);
      chk("t1_ram_en_T", ram_en, 0);
      tick(); p0_req_valid = 1'b0; #1;
      chk("t1_ram_en", ram_en, 1);
      chk("t1_ram_addr", 64'(ram_addr), 64'd8);
      chk("t1_ram_we", ram_we, 0);
      chk("t1_p0_ready_busy", p0_req_ready, 0);
      tick(); #1;
      chk("t1_no_early_resp", p0_resp_valid, 0);
      tick(); #1;
      chk("t1_resp_valid", p0_resp_valid, 1);
      chk("t1_resp_rdata", p0_resp_rdata, 64'hDEAD_BEEF_0000_0001);
      chk("t1_resp_err", p0_resp_err, 0);
      chk("t1_p1_resp_valid", p1_resp_valid, 0);
      chk("t1_p1_resp_rdata", p1_resp_rdata, 0);
      tick(); #1;
      chk("t1_resp_one_cycle", p0_resp_valid, 0);
      chk("t1_rdata_idle_zero", p0_resp_rdata, 0);

      // 2: simultaneous requests right after reset; p1 wins the first tie.
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      tick(); p0_req_valid = 1'b1; p0_addr = 64'h0; p1_req_valid = 1'b1; p1_addr = 64'h8; #1;
      chk("t2_p1_ready", p1_req_ready, 1);
      chk("t2_p0_ready", p0_req_ready, 0);
      tick(); p1_req_valid = 1'b0; #1;
      chk("t2_ram_addr_p1", 64'(ram_addr), 64'd1);
      chk("t2_p0_ready_busy", p0_req_ready, 0);
      tick();
      tick(); #1;
      chk("t2_p1_resp_valid", p1_resp_valid, 1);
      chk("t2_p1_resp_rdata", p1_resp_rdata, 64'h0123_4567_89AB_CDEF);
      chk("t2_p0_resp_valid_off", p0_resp_valid, 0);
      chk("t2_p0_ready_resp", p0_req_ready, 0);
      tick(); #1;
      chk("t2_p0_ready_T4", p0_req_ready, 1);
      tick(); p0_req_valid = 1'b0; #1;
      chk("t2_ram_addr_p0", 64'(ram_addr), 64'd0);
      tick();
      tick(); #1;
      chk("t2_p0_resp_valid", p0_resp_valid, 1);
      chk("t2_p0_resp_rdata", p0_resp_rdata, 64'h0000_0000_CAFE_F00D);

      // 3: p1 masked write then read-back.
      tick(); p1_req_valid = 1'b1; p1_we = 1'b1; p1_addr = 64'h10;
      p1_wdata = 64'h1122_3344_5566_7788; p1_wmask = 8'h0F; #1;
      chk("t3_wr_ready", p1_req_ready, 1);
      tick(); p1_req_valid = 1'b0; p1_we = 1'b0; #1;
      chk("t3_ram_en", ram_en, 1);
      chk("t3_ram_we", ram_we, 1);
      chk("t3_ram_wmask", 64'(ram_wmask), 64'h0F);
      chk("t3_ram_addr", 64'(ram_addr), 64'd2);
      chk("t3_ram_wdata", ram_wdata, 64'h1122_3344_5566_7788);
      tick();
      tick(); #1;
      chk("t3_wr_resp_valid", p1_resp_valid, 1);
      chk("t3_wr_resp_rdata", p1_resp_rdata, 0);
      chk("t3_wr_resp_err", p1_resp_err, 0);
      tick(); p1_req_valid = 1'b1; p1_addr = 64'h10; #1;
      chk("t3_rd_ready", p1_req_ready, 1);
      tick(); p1_req_valid = 1'b0; #1;
      chk("t3_rd_ram_we", ram_we, 0);
      tick();
      tick(); #1;
      chk("t3_rd_resp_valid", p1_resp_valid, 1);
      chk("t3_rd_resp_rdata", p1_resp_rdata, 64'hAAAA_BBBB_5566_7788);

      // 4: first out-of-range word address.
      en_before = en_cnt;
      tick(); p0_req_valid = 1'b1; p0_addr = 64'h8000; #1;
      chk("t4_ready", p0_req_ready, 1);
      tick(); p0_req_valid = 1'b0; #1;
      chk("t4_resp_valid", p0_resp_valid, 1);
      chk("t4_resp_err", p0_resp_err, 1);
      chk("t4_resp_rdata", p0_resp_rdata, 0);
      chk("t4_ram_en", ram_en, 0);
      tick(); #1;
      chk("t4_resp_done", p0_resp_valid, 0);
      tick(); #1;
      chk("t4_no_ram_access", 64'(en_cnt), 64'(en_before));

      // 5: reset during WAIT drops the outstanding read.
      en_before   = en_cnt;
      resp_before = p0_resp_cnt;
      tick(); p0_req_valid = 1'b1; p0_addr = 64'h40; #1;
      chk("t5_ready", p0_req_ready, 1);
      tick(); p0_req_valid = 1'b0;
      tick(); rst = 1'b1; #1;
      chk("t5_rst_resp_valid", p0_resp_valid, 0);
      chk("t5_rst_resp_rdata", p0_resp_rdata, 0);
      chk("t5_rst_ram_en", ram_en, 0);
      tick(); #1;
      chk("t5_rst2_ram_en", ram_en, 0);
      tick(); rst = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t5_no_resp", 64'(p0_resp_cnt), 64'(resp_before));
      chk("t5_one_ram_en", 64'(en_cnt), 64'(en_before + 1));
      tick(); p0_req_valid = 1'b1; p0_addr = 64'h40; #1;
      chk("t5_again_ready", p0_req_ready, 1);
      tick(); p0_req_valid = 1'b0;
      tick();
      tick(); #1;
      chk("t5_again_resp_valid", p0_resp_valid, 1);
      chk("t5_again_resp_rdata", p0_resp_rdata, 64'hDEAD_BEEF_0000_0001);

      // 6: RAM_LATENCY=3 instance; p0 kept pending so ready stays meaningful.
      tick(); b_p1_req_valid = 1'b1; b_p1_addr = 64'h8; #1;
      chk("t6_ready", b_p1_req_ready, 1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) begin
            b_p1_req_valid = 1'b0;
            b_p0_req_valid = 1'b1;
         end
         #1;
         chk($sformatf("t6_p0_ready_T%0d", k), b_p0_req_ready, 0);
         chk($sformatf("t6_p1_ready_T%0d", k), b_p1_req_ready, 0);
         chk($sformatf("t6_ram_en_T%0d", k), b_ram_en, 64'(k == 1));
         chk($sformatf("t6_resp_valid_T%0d", k), b_p1_resp_valid, 64'(k == 5));
      end
      chk("t6_resp_rdata", b_p1_resp_rdata, 64'h0123_4567_89AB_CDEF);
      tick(); b_p0_req_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the address-translation unit's two memory request channels: port 0 carries instruction-side accesses and port 1 carries data-side accesses. Both channels include page-table-entry reads.
It arbitrates the two channels onto one single-ported synchronous RAM, with a fixed read latency. Each accepted request gets exactly one response on the port that issued it.
It sits between the translator/MMU and main memory.

Parameters:
RAM_LATENCY, 1, cycles from ram_en to valid ram_rdata (must be ≥1).
MEM_WORDS, 4096, number of 64-bit words in RAM; addresses at or beyond MEM_WORDS*8 are out of range.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
p0_req_valid  in  1  port-0 request present.
p0_req_ready  out  1  port-0 request accepted this cycle.
p0_addr  in  64  byte address.
p0_we  in  1  1 = write, 0 = read.
p0_wdata  in  64  write data.
p0_wmask  in  8  byte enables for writes.
p0_resp_valid  out  1  one-cycle response strobe.
p0_resp_rdata  out  64  read data; 0 for writes and errors.
p0_resp_err  out  1  out-of-range access.
p1_req_valid, p1_req_ready, p1_addr, p1_we, p1_wdata, p1_wmask, p1_resp_valid, p1_resp_rdata, p1_resp_err: identical to port 0, for port 1.
ram_en  out  1  RAM access strobe.
ram_we  out  1  RAM write.
ram_addr  out  61  word index, equal to addr[63:3].
ram_wdata  out  64  write data.
ram_wmask  out  8  byte enables.
ram_rdata  in  64  read data, valid RAM_LATENCY cycles after ram_en.

Behaviour:
- Clocking and reset: all state changes on rising clk. While rst is high, every output is 0, the FSM is in IDLE, the wait counter is 0 and last_grant is 0.
- Only one request is outstanding in the whole block at any time.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant selection: if exactly one port is valid, that port is granted. If both are valid, grant the port opposite to last_grant (round-robin); the first tie after reset therefore goes to port 1.
  - The granted port's req_ready is 1 combinationally in the same cycle; the other port's req_ready is 0.
  - On handshake (valid && ready) at cycle T: latch addr, we, wdata, wmask and the port ID; update last_grant to the granted port.
  - If the address is in range, go to ISSUE; otherwise go to RESP with the error flag set.
- ISSUE (cycle T+1): ram_en=1 for exactly this cycle; ram_we, ram_addr, ram_wdata and ram_wmask come from the latched request. Load the counter with RAM_LATENCY and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture ram_rdata (reads only) and go to RESP.
- RESP: raise resp_valid for one cycle on the owning port only, then return to IDLE. No new request is accepted in a RESP cycle.
- Latency:
  - In-range read or write: resp_valid at cycle T+2+RAM_LATENCY (T+3 for the default).
  - Out-of-range request: resp_valid at T+1 with resp_err=1 and resp_rdata=0; no RAM access occurs.
- Writes return a response with rdata=0 and err=0.
- Address handling: addr[2:0] is ignored for addressing; the byte mask carries sub-word intent. The range check is addr[63:3] < MEM_WORDS.
- Requester rules:
  - The requester holds request fields stable while valid and not yet accepted.
  - The requester may drop valid before acceptance; nothing is latched in that case.
  - Responses need no ready signal; the requester must always sink them.
- Ready behaviour: req_ready is 0 in every state other than IDLE, for both ports.
- Reset while a request is outstanding: the request is discarded. No response is produced, no further ram_en is issued, and the FSM returns to IDLE.
- Unused response fields are 0 whenever the corresponding resp_valid is 0.

Decomposition:
- Shared package mem_pkg holds:
  - the state enumeration {IDLE, ISSUE, WAIT, RESP};
  - the request struct {addr, we, wdata, wmask};
  - the response struct {rdata, err};
  - the MEM_WORDS default;
  - a WORD_SHIFT=3 constant.
- One sub-module, rr_arbiter2: a two-requester round-robin grant with a last_grant register updated on an accept pulse.

Test Plan:
1. Reset, then p0 reads addr 0x40 with RAM word 8 = 0xDEADBEEF_00000001 → p0_req_ready at T; ram_en with ram_addr=8 at T+1; p0_resp_valid at T+3 with rdata=0xDEADBEEF_00000001; p1 outputs stay 0.
2. After reset, p0 and p1 both valid in the same cycle (reads of 0x0 and 0x8) → p1 granted first and responded at T+3; p0 granted in the next IDLE cycle (T+4) and responded at T+7.
3. p1 writes addr 0x10, wdata 0x1122334455667788, wmask 0x0F, followed by a p1 read of 0x10 → ram_we=1 with ram_wmask=0x0F; write response has rdata=0 and err=0; the read returns the low 4 bytes updated.
4. p0 reads addr MEM_WORDS*8 → resp_valid at T+1 with resp_err=1 and rdata=0; ram_en never asserted.
5. rst pulsed in a WAIT cycle of an outstanding p0 read → no p0_resp_valid ever appears; all outputs 0 during reset; a subsequent p0 request completes normally with T+3 latency.
6. RAM_LATENCY=3 build: p1 read → ram_en at T+1, resp_valid at T+5; both req_ready remain 0 from T+1 through T+5.
